// File: rtl/light_show_pkg.sv
`default_nettype none
// ============================================================================
// Module   : light_show_pkg
// Brief    : Shared constants, duty type and phase helper for the light-show
//            PWM path.
// Revision : 1.0 - initial release
// ============================================================================
package light_show_pkg;

    localparam int DUTY_W     = 15;
    localparam int PWM_PERIOD = 32768;
    localparam int PHASE_G    = 10922;
    localparam int PHASE_B    = 21844;

    typedef logic [DUTY_W-1:0] duty_t;

    // Largest duty word; treated as "lit for the whole period".
    localparam duty_t c_duty_full = duty_t'(PWM_PERIOD - 1);

    // Position of the counter within a channel's rotated period.
    // Plain 15-bit subtraction gives the modulo-2^15 wrap for free.
    function automatic duty_t phase_of(input duty_t cnt, input duty_t offset);
        return cnt - offset;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_channel.sv
`default_nettype none
// ============================================================================
// Module   : pwm_channel
// Brief    : One PWM channel: shadow duty register, phase offset, compare
//            with full-on case, registered output with polarity.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_channel
    import light_show_pkg::*;
#(
    parameter duty_t OFFSET      = '0,
    parameter bit    ACTIVE_HIGH = 1'b1
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  i_load,
    input  logic  i_run,
    input  duty_t i_duty,
    input  duty_t i_cnt,
    output logic  o_led
);

    duty_t r_shadow;
    logic  r_led;
    duty_t w_phase;
    logic  w_lit;

    assign w_phase = phase_of(i_cnt, OFFSET);
    // Duty 0 can never satisfy phase < 0, so a dark channel stays fully dark.
    assign w_lit   = (r_shadow == c_duty_full) || (w_phase < r_shadow);

    // Shadow duty: captured only when the top level says it is safe to switch.
    always_ff @(posedge clk) begin
        if (i_load) begin
            r_shadow <= i_duty;
        end
    end

    // Registered LED drive; idle level whenever the channel is not running.
    always_ff @(posedge clk) begin
        if (rst || !i_run) begin
            r_led <= ~ACTIVE_HIGH;
        end else begin
            r_led <= ACTIVE_HIGH ? w_lit : ~w_lit;
        end
    end

    assign o_led = r_led;

endmodule
`default_nettype wire

// File: rtl/rgb_led_pwm.sv
`default_nettype none
// ============================================================================
// Module   : rgb_led_pwm
// Brief    : Three-channel RGB LED PWM driver with prescaler, period-boundary
//            duty double-buffering and optional phase staggering.
// Revision : 1.0 - initial release
// ============================================================================
module rgb_led_pwm
    import light_show_pkg::*;
#(
    parameter int PRESCALE      = 1,
    parameter bit ACTIVE_HIGH   = 1'b1,
    parameter bit PHASE_STAGGER = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DUTY_W-1:0] red,
    input  logic [DUTY_W-1:0] green,
    input  logic [DUTY_W-1:0] blue,
    output logic              led_r,
    output logic              led_g,
    output logic              led_b,
    output logic              period_start
);

    localparam logic [15:0] c_pre_last = 16'(PRESCALE - 1);
    localparam duty_t       c_cnt_last = duty_t'(PWM_PERIOD - 1);
    localparam duty_t       c_off_r    = '0;
    localparam duty_t       c_off_g    = PHASE_STAGGER ? duty_t'(PHASE_G) : '0;
    localparam duty_t       c_off_b    = PHASE_STAGGER ? duty_t'(PHASE_B) : '0;

    logic [15:0] r_pre;
    duty_t       r_cnt;
    logic        r_period_start;

    logic        w_pre_tc;
    logic        w_wrap;
    logic        w_load;

    assign w_pre_tc = (r_pre == c_pre_last);
    assign w_wrap   = w_pre_tc && (r_cnt == c_cnt_last);
    // While idle the shadows track the inputs, so the first period after
    // enable uses the values present on the last idle cycle.
    assign w_load   = rst || !en || w_wrap;

    // Prescaler, period counter and period-start pulse.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_pre          <= '0;
            r_cnt          <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_period_start <= (r_cnt == '0) && (r_pre == '0);
            if (w_pre_tc) begin
                r_pre <= '0;
                r_cnt <= r_cnt + duty_t'(1);
            end else begin
                r_pre <= r_pre + 16'd1;
            end
        end
    end

    pwm_channel #(
        .OFFSET      (c_off_r),
        .ACTIVE_HIGH (ACTIVE_HIGH)
    ) u_ch_r (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_run  (en),
        .i_duty (red),
        .i_cnt  (r_cnt),
        .o_led  (led_r)
    );

    pwm_channel #(
        .OFFSET      (c_off_g),
        .ACTIVE_HIGH (ACTIVE_HIGH)
    ) u_ch_g (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_run  (en),
        .i_duty (green),
        .i_cnt  (r_cnt),
        .o_led  (led_g)
    );

    pwm_channel #(
        .OFFSET      (c_off_b),
        .ACTIVE_HIGH (ACTIVE_HIGH)
    ) u_ch_b (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_run  (en),
        .i_duty (blue),
        .i_cnt  (r_cnt),
        .o_led  (led_b)
    );

    assign period_start = r_period_start;

endmodule
`default_nettype wire

// File: doc/rgb_led_pwm.md
# rgb_led_pwm

Converts the three 15-bit RGB brightness words produced by the light-show pattern generator into PWM drive signals for one Arty S7 RGB LED. Sits directly downstream of the pattern generator and directly upstream of the LED output pins. Duty values are double-buffered and take effect only at a PWM period boundary, so the LED never glitches when the pattern changes. Channels are phase-staggered to spread switching edges.

## Interface

- PRESCALE, 1: clk cycles per PWM count; legal range 1..65535.
- ACTIVE_HIGH, 1: 1 means the LED is lit when its output is 1; 0 inverts all three LED outputs.
- PHASE_STAGGER, 1: 1 applies offsets of 0, 10922 and 21844 counts to R, G and B; 0 applies no offsets.

Ports:

- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- en  in  1  run enable
- red  in  15  red duty (0 = off, 32767 = fully on)
- green  in  15  green duty
- blue  in  15  blue duty
- led_r  out  1  red drive
- led_g  out  1  green drive
- led_b  out  1  blue drive
- period_start  out  1  one-cycle pulse at the start of each PWM period

## Operation

- Reset, or `en`=0:
  - prescaler, `cnt` and `period_start` are 0.
  - LED outputs are at the inactive level (0 if ACTIVE_HIGH=1, else 1).
  - Shadow duties load red/green/blue every cycle. The first period after enable therefore uses the inputs sampled on the last cycle with `en`=0.
- `rst` has priority over `en`. Reset mid-period is immediate: there is no completion of the current period.
- Counting:
  - The prescaler counts 0..PRESCALE-1.
  - `cnt` (15 bit) increments when the prescaler is at terminal count.
  - `cnt` wraps from 32767 to 0, giving a period of 32768×PRESCALE clk cycles.
- Shadow update:
  - Occurs on the cycle where the prescaler is terminal and `cnt`=32767.
  - The new duty applies from `cnt`=0 onward.
  - Inputs changing at any other time have no effect until the next wrap.
- Per-channel compare:
  - phase = (`cnt` − offset) mod 2^15, computed as 15-bit unsigned wrap.
  - The channel is lit iff phase < shadow duty.
  - Special case: a shadow duty of 32767 forces the channel lit for the whole period.
- Duty 0 keeps the channel dark for the entire period; there is no single-count sliver.
- The inputs feeding the compare are `cnt` and the shadow duties only. Inputs are not required to be stable between wraps.

## Timing

- LED outputs and `period_start` are registered: the output reflects the compare on the previous cycle's `cnt` and shadow state.
- `period_start` asserts for 1 clk on the cycle after the cycle where `cnt`=0 and the prescaler is 0.
- Latency from `en` rising to the first compare-driven output: 1 cycle.
- Latency from `en` falling to the outputs going inactive: 1 cycle.
- Lit-count behaviour with PHASE_STAGGER=0:
  - A channel with duty D (0 < D < 32767) is lit for exactly D×PRESCALE consecutive clk cycles per period.
  - Those cycles start at the period start.
- With stagger enabled:
  - The lit count is identical.
  - The lit window is rotated by the channel offset and may wrap across the period boundary.
- Duty changes mid-period:
  - Produce no change in the current period.
  - Take effect at the first output of the next period.

## Structure

- Shared package `light_show_pkg` holds:
  - DUTY_W = 15
  - PWM_PERIOD = 32768
  - PHASE_G = 10922
  - PHASE_B = 21844
- Sub-module `pwm_channel` is instantiated three times. It contains:
  - shadow duty register
  - offset subtract
  - compare with full-on special case
  - output register with polarity
- The top level contains the prescaler, `cnt`, the wrap/load strobe, `period_start` and the enable gating.

## Test plan

- **Reset/disable.** Assert `rst` for 3 cycles with inputs at 1000 → all LEDs are at the inactive level, `period_start`=0, and `cnt`=0 throughout.
- **Duty accuracy** (PRESCALE=1, PHASE_STAGGER=0). Drive red=1000, green=0, blue=32767 → over one 32768-cycle period:
  - led_r is high for exactly 1000 cycles starting at the `period_start` pulse;
  - led_g never goes high;
  - led_b never goes low.
- **Shadow timing.** Change red from 1000 to 5000 at `cnt`=200 → the current period still shows 1000 high cycles; the next period shows 5000.
- **Stagger** (PHASE_STAGGER=1). Drive all duties = 100 → the rising edges of led_r, led_g and led_b occur 0, 10922 and 21844 cycles after `period_start`; each is high for 100 cycles.
- **Wrap-around window.** With stagger on, blue=15000 → led_b is high from count 21844 to the end of the period and continues across the boundary, for 15000 cycles total.
- **Prescale and polarity.** PRESCALE=3, ACTIVE_HIGH=0, red=10 → the period is 98304 cycles and led_r is low for exactly 30 cycles per period. Deasserting `en` mid-period drives led_r to 1 within 1 cycle.
